camera_ctrl: RTL and testbench



---
 rtl/camera_ctrl_pkg.sv | 22 ++
 rtl/block_index_div.sv | 44 ++++
 rtl/camera_ctrl.sv | 95 +++++++++
 tb/tb_camera_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/camera_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | camera_ctrl_pkg : geometry constants and FSM encoding for the scroll ctl |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package camera_ctrl_pkg;

  localparam int PHY_WIDTH    = 14;
  localparam int BLOCK_WIDTH  = 480;
  localparam int CHAR_WIDTH_Y = 32;
  localparam int CAM_WIDTH    = 5;
  localparam int MAX_BLOCK    = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_BLANK  = 2'd3
  } cam_state_t;

endpackage
`default_nettype wire

// File: rtl/block_index_div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | block_index_div : iterative subtract-and-count block index, saturating   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module block_index_div
  import camera_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 run,
  input  logic [PHY_WIDTH-1:0] y,
  output logic                 done,
  output logic [CAM_WIDTH-1:0] idx
);

  localparam int                   REM_W   = PHY_WIDTH + 1;
  localparam logic [REM_W-1:0]     HALF_H  = REM_W'(CHAR_WIDTH_Y / 2);
  localparam logic [REM_W-1:0]     BLOCK_H = REM_W'(BLOCK_WIDTH);
  localparam logic [CAM_WIDTH-1:0] IDX_MAX = CAM_WIDTH'(MAX_BLOCK - 1);

  logic [REM_W-1:0] rem;
  logic             can_step;

  // Stopping at IDX_MAX saturates the quotient instead of wrapping idx.
  assign can_step = (rem >= BLOCK_H) && (idx < IDX_MAX);
  assign done     = ~can_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      idx <= '0;
    end else if (start) begin
      rem <= {1'b0, y} + HALF_H;
      idx <= '0;
    end else if (run && can_step) begin
      rem <= rem - BLOCK_H;
      idx <= idx + CAM_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/camera_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | camera_ctrl : per-frame position shadowing, camera block index, blanking |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module camera_ctrl
  import camera_ctrl_pkg::*;
#(
  parameter int BLANK_FRAMES = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 frame_start,
  input  logic [PHY_WIDTH-1:0] char_abs_x,
  input  logic [PHY_WIDTH-1:0] char_abs_y,
  output logic [PHY_WIDTH-1:0] char_x_q,
  output logic [PHY_WIDTH-1:0] char_y_q,
  output logic [CAM_WIDTH-1:0] camera_y,
  output logic                 blank,
  output logic                 scroll_evt,
  output logic                 busy
);

  localparam int CNT_W = $clog2(BLANK_FRAMES + 1);

  cam_state_t           state, next_state;
  logic                 latch_en, div_start, div_run, div_done;
  logic                 commit_chg, blank_step, blank_end;
  logic [CAM_WIDTH-1:0] idx;
  logic [CNT_W-1:0]     blank_cnt;

  block_index_div u_div (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .start (div_start),
    .run   (div_run),
    .y     (char_abs_y),
    .done  (div_done),
    .idx   (idx)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (frame_start) next_state = ST_CALC;
      ST_CALC:   if (div_done)    next_state = ST_COMMIT;
      ST_COMMIT: next_state = commit_chg ? ST_BLANK : ST_IDLE;
      ST_BLANK:  if (blank_end)   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Strobes arriving in CALC/COMMIT are dropped: no latch and no restart.
  always_comb begin
    latch_en   = frame_start && (state == ST_IDLE || state == ST_BLANK);
    div_start  = frame_start && (state == ST_IDLE);
    div_run    = (state == ST_CALC);
    commit_chg = (state == ST_COMMIT) && (idx != camera_y);
    blank_step = frame_start && (state == ST_BLANK);
    blank_end  = blank_step && (blank_cnt == CNT_W'(1));
    busy       = (state != ST_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      char_x_q   <= '0;
      char_y_q   <= '0;
      camera_y   <= '0;
      blank      <= 1'b0;
      scroll_evt <= 1'b0;
      blank_cnt  <= '0;
    end else begin
      scroll_evt <= commit_chg;
      if (latch_en) begin
        char_x_q <= char_abs_x;
        char_y_q <= char_abs_y;
      end
      if (commit_chg) begin
        camera_y  <= idx;
        blank     <= 1'b1;
        blank_cnt <= CNT_W'(BLANK_FRAMES);
      end else if (blank_step) begin
        blank_cnt <= blank_cnt - CNT_W'(1);
        if (blank_end) blank <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_camera_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_camera_ctrl : directed + randomized bench with a quotient-level model |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_camera_ctrl;

  localparam int BLOCK    = 480;
  localparam int CHAR_Y   = 32;
  localparam int MAXB     = 32;
  localparam int BLANK_FR = 2;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        frame_start;
  logic [13:0] char_abs_x, char_abs_y;
  logic [13:0] char_x_q, char_y_q;
  logic [4:0]  camera_y;
  logic        blank, scroll_evt, busy;

  int tests  = 0;
  int failed = 0;

  // Reference model: current block, blanking frames still owed.
  int m_cam      = 0;
  bit m_in_blank = 0;
  int m_left     = 0;

  camera_ctrl #(.BLANK_FRAMES(BLANK_FR)) dut (
    .sys_clk     (clk),
    .sys_rst     (sys_rst),
    .frame_start (frame_start),
    .char_abs_x  (char_abs_x),
    .char_abs_y  (char_abs_y),
    .char_x_q    (char_x_q),
    .char_y_q    (char_y_q),
    .camera_y    (camera_y),
    .blank       (blank),
    .scroll_evt  (scroll_evt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_block(input int y);
    int q;
    q = (y + CHAR_Y / 2) / BLOCK;
    return (q > MAXB - 1) ? MAXB - 1 : q;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_x"},     char_x_q,   0);
    check({tag, "_y"},     char_y_q,   0);
    check({tag, "_cam"},   camera_y,   0);
    check({tag, "_blank"}, blank,      0);
    check({tag, "_evt"},   scroll_evt, 0);
    check({tag, "_busy"},  busy,       0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    m_cam = 0; m_in_blank = 0; m_left = 0;
  endtask

  // One frame strobe, checked against the model whichever mode it lands in.
  task automatic do_frame(input int x, input int y);
    int q;
    bit chg;
    char_abs_x  = x[13:0];
    char_abs_y  = y[13:0];
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("x_latch", char_x_q, x);
    check("y_latch", char_y_q, y);
    if (!m_in_blank) begin
      q   = ref_block(y);
      chg = (q != m_cam);
      check("busy_calc", busy, 1);
      repeat (q + 1) tick();
      check("busy_commit", busy, 1);
      check("cam_hold", camera_y, m_cam);
      check("evt_early", scroll_evt, 0);
      tick();
      check("cam_new", camera_y, q);
      check("evt", scroll_evt, chg);
      check("blank_on", blank, chg);
      check("busy_end", busy, chg);
      tick();
      check("evt_pulse", scroll_evt, 0);
      m_cam = q;
      if (chg) begin
        m_in_blank = 1;
        m_left     = BLANK_FR;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_in_blank = 0;
      check("blank_win", blank, m_in_blank);
      check("busy_blank", busy, m_in_blank);
      check("cam_blank", camera_y, m_cam);
      check("evt_blank", scroll_evt, 0);
    end
    repeat (3) tick();
  endtask

  initial begin
    sys_rst     = 1'b1;
    frame_start = 1'b0;
    char_abs_x  = '0;
    char_abs_y  = '0;
    repeat (3) tick();
    sys_rst = 1'b0;
    check_zero("reset");

    do_frame(11, 100);
    do_frame(22, 1000);
    do_frame(33, 1010);
    do_frame(44, 1020);
    check("idle_after_blank", busy, 0);
    do_frame(55, 16383);
    do_frame(66, 5);
    do_frame(77, 6);
    do_frame(88, 1000);
    do_frame(99, 1);
    do_frame(100, 2);
    do_frame(123, 400);
    do_frame(234, 3);
    do_frame(345, 4);

    // Strobes during CALC with new positions must be ignored.
    char_abs_x  = 14'd500;
    char_abs_y  = 14'd5000;
    frame_start = 1'b1;
    tick();
    char_abs_x  = 14'd7;
    char_abs_y  = 14'd100;
    tick();
    frame_start = 1'b0;
    check("inj_y_hold", char_y_q, 5000);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("inj_x_hold", char_x_q, 500);
    repeat (9) tick();
    check("inj_cam", camera_y, ref_block(5000));
    check("inj_evt", scroll_evt, 1);
    check("inj_blank", blank, 1);
    m_cam = ref_block(5000); m_in_blank = 1; m_left = BLANK_FR;
    repeat (3) tick();
    do_frame(1, 2);
    do_frame(3, 4);

    // Reset in the middle of CALC.
    char_abs_x  = 14'd9;
    char_abs_y  = 14'd16383;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (5) tick();
    do_reset();
    check_zero("rst_calc");
    do_frame(5, 1000);

    // Reset in the middle of BLANK.
    do_frame(6, 7);
    do_reset();
    check_zero("rst_blank");
    do_frame(8, 2000);

    for (int i = 0; i < 24; i++) begin
      do_frame(int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
